// File: rtl/cnn_img_fetch_dma_pkg.sv
// Shared AHB-Lite encodings and DMA state type
// for the CNN image fetch path.
package cnn_img_fetch_dma_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam int W_BURST = 3;
    localparam logic [W_BURST-1:0] HBURST_SINGLE = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DRAIN,
        ST_DONE,
        ST_ERR
    } dma_state_t;

endpackage

// File: rtl/cnn_img_fetch_dma_fifo.sv
// Synchronous word FIFO between the AHB read
// side and the CNN pixel stream.
module cnn_stream_fifo #(
    parameter int W_DATA = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W_DATA-1:0]        push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [W_DATA-1:0]        head
);

    localparam int W_PTR = $clog2(DEPTH);
    localparam logic [W_PTR-1:0] PTR_ONE = W_PTR'(1);
    localparam logic [W_PTR:0] CNT_ONE = (W_PTR+1)'(1);
    localparam logic [W_PTR:0] CNT_MAX = (W_PTR+1)'(DEPTH);

    logic [W_DATA-1:0] mem [DEPTH];
    logic [W_PTR-1:0]  wr_ptr;
    logic [W_PTR-1:0]  rd_ptr;
    logic              pop_ok;
    logic              push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_MAX);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push_ok && !pop_ok)
                count <= count + CNT_ONE;
            else if (pop_ok && !push_ok)
                count <= count - CNT_ONE;
        end
    end

    // Storage has no reset; only slots below count are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cnn_img_fetch_dma.sv
// AHB-Lite read master streaming image words
// from BRAM into the CNN compute core.
module cnn_img_fetch_dma
    import cnn_img_fetch_dma_pkg::*;
#(
    parameter int W_ADDR     = 32,
    parameter int W_DATA     = 32,
    parameter int W_CNT      = 14,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               i_start,
    input  logic [W_ADDR-1:0]  i_base_addr,
    input  logic [W_CNT-1:0]   i_n_words,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    input  logic               i_HREADY,
    input  logic [1:0]         i_HRESP,
    input  logic [W_DATA-1:0]  i_HRDATA,
    output logic [W_ADDR-1:0]  o_HADDR,
    output logic [1:0]         o_HTRANS,
    output logic               o_HWRITE,
    output logic [2:0]         o_HSIZE,
    output logic [W_BURST-1:0] o_HBURST,
    output logic [W_DATA-1:0]  o_HWDATA,
    output logic               o_pix_valid,
    output logic [W_DATA-1:0]  o_pix_data,
    input  logic               i_pix_ready
);

    localparam int W_FCNT = $clog2(FIFO_DEPTH) + 1;
    localparam logic [W_FCNT:0] F_ONE = (W_FCNT+1)'(1);
    localparam logic [W_FCNT:0] F_LIM = (W_FCNT+1)'(FIFO_DEPTH);
    localparam logic [W_CNT-1:0] C_ONE = W_CNT'(1);
    localparam logic [W_ADDR-1:0] STEP  = W_ADDR'(4);
    localparam logic [W_ADDR-1:0] ALIGN = ~(W_ADDR'(3));

    dma_state_t        state;
    logic [W_CNT-1:0]  addr_left;
    logic [W_CNT-1:0]  data_left;
    logic              dphase;

    logic              fifo_full;
    logic              fifo_empty;
    logic [W_FCNT-1:0] fifo_count;

    logic              acc_addr;
    logic              data_ok;
    logic              err_cyc;
    logic              push;
    logic              pop;
    logic              dphase_nxt;
    logic              addr_more;
    logic [W_FCNT:0]   cnt_sum;
    logic              room;

    assign o_HWRITE = 1'b0;
    assign o_HSIZE  = HSIZE_WORD;
    assign o_HBURST = HBURST_SINGLE;
    assign o_HWDATA = '0;

    assign acc_addr = (o_HTRANS == HTRANS_NONSEQ) && i_HREADY;
    assign data_ok  = dphase && i_HREADY && (i_HRESP == HRESP_OKAY);
    assign err_cyc  = dphase && (i_HRESP == HRESP_ERROR);
    assign push     = data_ok && (!fifo_full || pop);
    assign pop      = o_pix_valid && i_pix_ready;
    assign o_pix_valid = !fifo_empty;

    assign dphase_nxt = i_HREADY ? acc_addr : dphase;
    assign addr_more  = acc_addr ? (addr_left != C_ONE)
                                 : (addr_left != '0);

    // Next-cycle FIFO occupancy including the word in flight;
    // a new address is issued only if its data is sure to fit.
    always_comb begin
        cnt_sum = {1'b0, fifo_count};
        if (push)       cnt_sum = cnt_sum + F_ONE;
        if (pop)        cnt_sum = cnt_sum - F_ONE;
        if (dphase_nxt) cnt_sum = cnt_sum + F_ONE;
    end

    assign room = (cnt_sum < F_LIM);

    // Transfer FSM with registered AHB control and status outputs.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            o_HADDR   <= '0;
            o_HTRANS  <= HTRANS_IDLE;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
            addr_left <= '0;
            data_left <= '0;
            dphase    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        o_err <= 1'b0;
                        if (i_n_words == '0) begin
                            state  <= ST_DONE;
                            o_done <= 1'b1;
                        end else begin
                            state     <= ST_ADDR;
                            o_busy    <= 1'b1;
                            o_HADDR   <= i_base_addr & ALIGN;
                            addr_left <= i_n_words;
                            data_left <= i_n_words;
                            o_HTRANS  <= room ? HTRANS_NONSEQ
                                              : HTRANS_IDLE;
                        end
                    end
                end
                ST_ADDR, ST_DRAIN: begin
                    dphase <= dphase_nxt;
                    if (acc_addr) begin
                        o_HADDR   <= o_HADDR + STEP;
                        addr_left <= addr_left - C_ONE;
                        if (addr_left == C_ONE) state <= ST_DRAIN;
                    end
                    if (data_ok) data_left <= data_left - C_ONE;
                    if (err_cyc) begin
                        // Cancel the pipelined address on the first
                        // error cycle; abort on the second.
                        o_HTRANS <= HTRANS_IDLE;
                        if (i_HREADY) begin
                            state  <= ST_ERR;
                            dphase <= 1'b0;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            o_err  <= 1'b1;
                        end
                    end else if (data_ok && data_left == C_ONE) begin
                        state    <= ST_DONE;
                        o_HTRANS <= HTRANS_IDLE;
                        o_busy   <= 1'b0;
                        o_done   <= 1'b1;
                    end else if (i_HREADY) begin
                        o_HTRANS <= (addr_more && room) ? HTRANS_NONSEQ
                                                        : HTRANS_IDLE;
                    end
                end
                ST_DONE, ST_ERR: begin
                    o_done <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    cnn_stream_fifo #(
        .W_DATA (W_DATA),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (HCLK),
        .rst       (HRESET),
        .push      (push),
        .push_data (i_HRDATA),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (o_pix_data)
    );

endmodule
